// File: rtl/ifmap_input_ctrl_param.sv
// ifmap_input_ctrl_param: ifmap input path controller that chains beats into words,
// writes them into a bank, and swaps the double buffer for a configured number of banks.
`timescale 1ns/1ps
module ifmap_input_ctrl_param #(
    parameter int CHAIN_LEN  = 4,
    parameter int BANK_DEPTH = 64,
    parameter int ADDR_W     = $clog2(BANK_DEPTH),
    parameter int BANK_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  config_en,
    input  logic [BANK_CNT_W-1:0] config_num_banks,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  en_input_chaining,
    output logic                  chaining_clear,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    input  logic                  ready_to_switch,
    output logic                  switch,
    output logic                  busy,
    output logic                  done
);
    localparam int BEAT_W = $clog2(CHAIN_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CHAIN_LEN - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BANK_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CHAIN, WRITE, WAIT_SW, SWITCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]     word_cnt_q, word_cnt_d;
    logic [BANK_CNT_W-1:0] bank_cnt_q, bank_cnt_d;
    logic [BANK_CNT_W-1:0] num_banks_q, num_banks_d;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        word_cnt_d  = word_cnt_q;
        bank_cnt_d  = bank_cnt_q;
        num_banks_d = num_banks_q;
        case (state_q)
            IDLE, DONE: begin
                if (config_en && config_num_banks != '0) begin
                    state_d     = CHAIN;
                    num_banks_d = config_num_banks;
                    beat_cnt_d  = '0;
                    word_cnt_d  = '0;
                    bank_cnt_d  = '0;
                end
            end
            CHAIN: begin
                if (in_valid) begin
                    beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
                    state_d    = (beat_cnt_q == LAST_BEAT) ? WRITE : CHAIN;
                end
            end
            WRITE: begin
                word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
                state_d    = (word_cnt_q == LAST_WORD) ? WAIT_SW : CHAIN;
            end
            WAIT_SW: state_d = ready_to_switch ? SWITCH : WAIT_SW;
            SWITCH: begin
                // num_banks_q is never zero here: a zero count never leaves IDLE/DONE
                if (bank_cnt_q == num_banks_q - 1'b1) begin
                    state_d = DONE;
                end else begin
                    bank_cnt_d = bank_cnt_q + 1'b1;
                    state_d    = CHAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            word_cnt_q  <= '0;
            bank_cnt_q  <= '0;
            num_banks_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            word_cnt_q  <= word_cnt_d;
            bank_cnt_q  <= bank_cnt_d;
            num_banks_q <= num_banks_d;
        end
    end

    // WRITE clears the chain because its word has just been captured by the bank
    assign in_ready          = (state_q == CHAIN);
    assign en_input_chaining = in_valid & in_ready;
    assign chaining_clear    = (state_q == IDLE) || (state_q == WRITE) || (state_q == DONE);
    assign wr_en             = (state_q == WRITE);
    assign wr_addr           = word_cnt_q;
    assign switch            = (state_q == SWITCH);
    assign busy              = (state_q != IDLE) && (state_q != DONE);
    assign done              = (state_q == DONE);
endmodule

// File: tb/tb_ifmap_input_ctrl_param.sv
// tb_ifmap_input_ctrl_param: directed bench for a depth-4 and a depth-5 instance,
// checked every cycle against a count-based model plus literal expectations.
`timescale 1ns/1ps
module tb_ifmap_input_ctrl_param;
    localparam int CL = 4;
    localparam int DEP [2] = '{4, 5};

    logic       clk = 1'b0;
    logic       rst [2];
    logic       cfg_en [2];
    logic [7:0] cfg_n [2];
    logic       iv [2];
    logic       rts [2];
    logic       o_rdy [2], o_en [2], o_clr [2], o_wr [2], o_sw [2], o_busy [2], o_done [2];
    logic [1:0] a4;
    logic [2:0] a5;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int wr_cnt [2], sw_cnt [2], beats [2], sw_prev [2], sw_last [2];
    int addr_log [2][$];

    bit m_run [2], m_wr [2], m_wait [2], m_sw [2], m_fin [2];
    int m_beats [2], m_words [2], m_banks [2], m_nb [2];

    always #5 clk = ~clk;

    ifmap_input_ctrl_param #(.CHAIN_LEN(CL), .BANK_DEPTH(4)) u4 (
        .clk(clk), .rst(rst[0]), .config_en(cfg_en[0]), .config_num_banks(cfg_n[0]),
        .in_valid(iv[0]), .in_ready(o_rdy[0]), .en_input_chaining(o_en[0]),
        .chaining_clear(o_clr[0]), .wr_en(o_wr[0]), .wr_addr(a4),
        .ready_to_switch(rts[0]), .switch(o_sw[0]), .busy(o_busy[0]), .done(o_done[0]));

    ifmap_input_ctrl_param #(.CHAIN_LEN(CL), .BANK_DEPTH(5)) u5 (
        .clk(clk), .rst(rst[1]), .config_en(cfg_en[1]), .config_num_banks(cfg_n[1]),
        .in_valid(iv[1]), .in_ready(o_rdy[1]), .en_input_chaining(o_en[1]),
        .chaining_clear(o_clr[1]), .wr_en(o_wr[1]), .wr_addr(a5),
        .ready_to_switch(rts[1]), .switch(o_sw[1]), .busy(o_busy[1]), .done(o_done[1]));

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: tracks beats in the current word, words in the bank, banks finished.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_run[k] = 0; m_wr[k] = 0; m_wait[k] = 0; m_sw[k] = 0; m_fin[k] = 0;
                m_beats[k] = 0; m_words[k] = 0; m_banks[k] = 0;
            end else if (!m_run[k]) begin
                if (cfg_en[k] && cfg_n[k] != 0) begin
                    m_run[k] = 1; m_fin[k] = 0; m_nb[k] = int'(cfg_n[k]);
                    m_beats[k] = 0; m_words[k] = 0; m_banks[k] = 0;
                end
            end else if (m_wr[k]) begin
                m_wr[k] = 0;
                m_words[k]++;
                if (m_words[k] == DEP[k]) begin m_words[k] = 0; m_wait[k] = 1; end
            end else if (m_wait[k]) begin
                if (rts[k]) begin m_wait[k] = 0; m_sw[k] = 1; end
            end else if (m_sw[k]) begin
                m_sw[k] = 0;
                m_banks[k]++;
                if (m_banks[k] == m_nb[k]) begin m_run[k] = 0; m_fin[k] = 1; end
            end else if (iv[k]) begin
                m_beats[k]++;
                if (m_beats[k] == CL) begin m_beats[k] = 0; m_wr[k] = 1; end
            end
        end
    end

    always @(negedge clk) begin
        int act_addr;
        bit e_rdy;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            act_addr = (k == 0) ? int'(a4) : int'(a5);
            e_rdy = m_run[k] && !m_wr[k] && !m_wait[k] && !m_sw[k];
            chk($sformatf("u%0d.in_ready", k), int'(o_rdy[k]), int'(e_rdy));
            chk($sformatf("u%0d.en_chain", k), int'(o_en[k]), int'(e_rdy && iv[k]));
            chk($sformatf("u%0d.clear", k), int'(o_clr[k]), int'(!m_run[k] || m_wr[k]));
            chk($sformatf("u%0d.wr_en", k), int'(o_wr[k]), int'(m_wr[k]));
            chk($sformatf("u%0d.switch", k), int'(o_sw[k]), int'(m_sw[k]));
            chk($sformatf("u%0d.busy", k), int'(o_busy[k]), int'(m_run[k]));
            chk($sformatf("u%0d.done", k), int'(o_done[k]), int'(m_fin[k]));
            if (m_wr[k]) chk($sformatf("u%0d.wr_addr", k), act_addr, m_words[k]);
            if (o_wr[k]) begin wr_cnt[k]++; addr_log[k].push_back(act_addr); end
            if (o_en[k]) beats[k]++;
            if (o_sw[k]) begin sw_cnt[k]++; sw_prev[k] = sw_last[k]; sw_last[k] = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic cfg(input int k, input int n);
        tick(); cfg_en[k] = 1'b1; cfg_n[k] = 8'(n);
        tick(); cfg_en[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lim);
        for (int i = 0; i < lim; i++) begin
            sample();
            if (o_done[k]) break;
        end
        chk($sformatf("u%0d.run_done", k), int'(o_done[k]), 1);
    endtask

    task automatic wait_wr(input int k, input int base, input int n);
        for (int i = 0; i < 200; i++) begin
            sample();
            if (wr_cnt[k] - base == n) break;
        end
        chk("wr_reached", wr_cnt[k] - base, n);
    endtask

    initial begin
        int b_wr, b_sw, b_bt, b_log;
        bit seen;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; cfg_en[k] = 1'b0; cfg_n[k] = '0; iv[k] = 1'b0; rts[k] = 1'b0;
            wr_cnt[k] = 0; sw_cnt[k] = 0; beats[k] = 0; sw_prev[k] = 0; sw_last[k] = 0;
        end
        sample();
        chk("rst.in_ready", int'(o_rdy[0]), 0);
        chk("rst.clear", int'(o_clr[0]), 1);
        chk("rst.busy", int'(o_busy[0]), 0);
        chk("rst.done", int'(o_done[0]), 0);
        chk("rst.wr_addr", int'(a4), 0);
        tick(); rst[0] = 1'b0;

        // 1: two banks, free-running input
        iv[0] = 1'b1; rts[0] = 1'b1;
        b_wr = wr_cnt[0]; b_sw = sw_cnt[0]; b_bt = beats[0]; b_log = addr_log[0].size();
        cfg(0, 2);
        wait_done(0, 200);
        chk("t1.switches", sw_cnt[0] - b_sw, 2);
        chk("t1.switch_gap", sw_last[0] - sw_prev[0], 22);
        chk("t1.writes", wr_cnt[0] - b_wr, 8);
        chk("t1.beats", beats[0] - b_bt, 32);
        if (addr_log[0].size() >= b_log + 8)
            for (int i = 0; i < 8; i++) chk("t1.addr_seq", addr_log[0][b_log + i], i % 4);

        // 2: read side holds its bank for 10 cycles
        rts[0] = 1'b0;
        b_wr = wr_cnt[0]; b_sw = sw_cnt[0];
        cfg(0, 2);
        wait_wr(0, b_wr, 4);
        for (int i = 0; i < 10; i++) begin
            tick(); sample();
            chk("t2.hold_ready", int'(o_rdy[0]), 0);
            chk("t2.hold_wr", int'(o_wr[0]), 0);
            chk("t2.hold_sw", int'(o_sw[0]), 0);
        end
        tick(); rts[0] = 1'b1;
        sample(); chk("t2.sw_not_yet", int'(o_sw[0]), 0);
        tick(); sample(); chk("t2.sw_fires", int'(o_sw[0]), 1);
        wait_done(0, 200);
        chk("t2.switches", sw_cnt[0] - b_sw, 2);

        // 3: in_valid toggles every cycle
        b_wr = wr_cnt[0]; b_sw = sw_cnt[0]; b_bt = beats[0]; seen = 0;
        cfg(0, 1);
        for (int i = 0; i < 200; i++) begin
            tick(); iv[0] = ~iv[0];
            sample();
            if (!seen && wr_cnt[0] - b_wr == 1) begin
                seen = 1;
                chk("t3.beats_at_first_wr", beats[0] - b_bt, 4);
            end
            if (o_done[0]) break;
        end
        chk("t3.done", int'(o_done[0]), 1);
        chk("t3.writes", wr_cnt[0] - b_wr, 4);
        chk("t3.beats", beats[0] - b_bt, 16);
        chk("t3.switches", sw_cnt[0] - b_sw, 1);

        // 4: reset mid-bank at word 2, beat 1
        iv[0] = 1'b1;
        b_wr = wr_cnt[0];
        cfg(0, 2);
        wait_wr(0, b_wr, 2);
        tick(); sample();
        tick(); rst[0] = 1'b1;
        tick(); rst[0] = 1'b0;
        sample();
        chk("t4.in_ready", int'(o_rdy[0]), 0);
        chk("t4.clear", int'(o_clr[0]), 1);
        chk("t4.busy", int'(o_busy[0]), 0);
        b_wr = wr_cnt[0]; b_sw = sw_cnt[0];
        repeat (5) tick();
        chk("t4.no_wr_after_rst", wr_cnt[0] - b_wr, 0);
        chk("t4.no_sw_after_rst", sw_cnt[0] - b_sw, 0);
        b_log = addr_log[0].size();
        cfg(0, 1);
        wait_done(0, 200);
        if (addr_log[0].size() > b_log) chk("t4.first_addr", addr_log[0][b_log], 0);
        chk("t4.writes", wr_cnt[0] - b_wr, 4);

        // 5: zero count ignored, mid-run reconfig ignored, restart from DONE
        tick(); rst[0] = 1'b1;
        tick(); rst[0] = 1'b0;
        cfg(0, 0);
        repeat (3) sample();
        chk("t5.zero_busy", int'(o_busy[0]), 0);
        chk("t5.zero_done", int'(o_done[0]), 0);
        b_sw = sw_cnt[0];
        cfg(0, 2);
        repeat (2) tick();
        cfg(0, 5);
        wait_done(0, 300);
        chk("t5.kept_count", sw_cnt[0] - b_sw, 2);
        b_sw = sw_cnt[0]; b_wr = wr_cnt[0];
        cfg(0, 1);
        wait_done(0, 200);
        chk("t5.restart_switches", sw_cnt[0] - b_sw, 1);
        chk("t5.restart_writes", wr_cnt[0] - b_wr, 4);

        // 6: non-power-of-two depth
        tick(); rst[1] = 1'b0; iv[1] = 1'b1; rts[1] = 1'b1;
        b_log = addr_log[1].size(); b_sw = sw_cnt[1];
        cfg(1, 1);
        wait_done(1, 200);
        chk("t6.writes", addr_log[1].size() - b_log, 5);
        if (addr_log[1].size() >= b_log + 5)
            for (int i = 0; i < 5; i++) chk("t6.addr_seq", addr_log[1][b_log + i], i);
        chk("t6.switches", sw_cnt[1] - b_sw, 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
